// File: rtl/i2s_adc_deserializer.sv
// I2S ADC deserializer: oversamples BCLK/LRCK/DATA in the clk domain and
// assembles signed left/right words with a one-cycle frame strobe.
module i2s_adc_deserializer #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     bclk,
  input  logic                     lrck,
  input  logic                     data,
  output logic signed [DATA_W-1:0] adc_left,
  output logic signed [DATA_W-1:0] adc_right,
  output logic                     sample_valid,
  output logic                     frame_err
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {SYNC, SHIFT, WAIT} state_t;

  logic [SYNC_STAGES-1:0] bclk_sr, lrck_sr, data_sr;
  logic                   bclk_dly, lrck_last;
  logic                   bclk_sync, lrck_sync, data_sync;
  logic                   edge_e, ch_start;

  state_t                 state, state_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic                   ch, ch_n;
  logic                   left_ok, left_ok_n;
  logic [DATA_W-1:0]      shift_reg, shift_n, hold, hold_n, word_next;
  logic [DATA_W-1:0]      left_n, right_n;
  logic                   sv_n, fe_n;

  assign bclk_sync = bclk_sr[SYNC_STAGES-1];
  assign lrck_sync = lrck_sr[SYNC_STAGES-1];
  assign data_sync = data_sr[SYNC_STAGES-1];
  assign edge_e    = bclk_sync & ~bclk_dly;
  assign ch_start  = edge_e & (lrck_sync != lrck_last);
  assign word_next = {shift_reg[DATA_W-2:0], data_sync};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_sr   <= '0;
      lrck_sr   <= '0;
      data_sr   <= '0;
      bclk_dly  <= 1'b0;
      lrck_last <= 1'b0;
    end else begin
      bclk_sr  <= {bclk_sr[SYNC_STAGES-2:0], bclk};
      lrck_sr  <= {lrck_sr[SYNC_STAGES-2:0], lrck};
      data_sr  <= {data_sr[SYNC_STAGES-2:0], data};
      bclk_dly <= bclk_sync;
      if (edge_e)
        lrck_last <= lrck_sync;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= SYNC;
      cnt          <= '0;
      ch           <= 1'b0;
      left_ok      <= 1'b0;
      shift_reg    <= '0;
      hold         <= '0;
      adc_left     <= '0;
      adc_right    <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      ch           <= ch_n;
      left_ok      <= left_ok_n;
      shift_reg    <= shift_n;
      hold         <= hold_n;
      adc_left     <= left_n;
      adc_right    <= right_n;
      sample_valid <= sv_n;
      frame_err    <= fe_n;
    end
  end

  // A channel start always wins over word completion, so a coincident
  // start counts as truncation and the edge becomes the new delay slot.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    ch_n      = ch;
    left_ok_n = left_ok;
    shift_n   = shift_reg;
    hold_n    = hold;
    left_n    = adc_left;
    right_n   = adc_right;
    sv_n      = 1'b0;
    fe_n      = 1'b0;
    if (edge_e) begin
      case (state)
        SYNC, WAIT: begin
          if (ch_start) begin
            state_n = SHIFT;
            cnt_n   = '0;
            ch_n    = lrck_sync;
            shift_n = '0;
          end
        end
        SHIFT: begin
          if (ch_start) begin
            fe_n      = 1'b1;
            left_ok_n = 1'b0;
            cnt_n     = '0;
            ch_n      = lrck_sync;
            shift_n   = '0;
          end else begin
            shift_n = word_next;
            cnt_n   = cnt + CNT_W'(1);
            if (cnt == CNT_W'(DATA_W - 1)) begin
              state_n = WAIT;
              if (!ch) begin
                hold_n    = word_next;
                left_ok_n = 1'b1;
              end else if (left_ok) begin
                left_n    = hold;
                right_n   = word_next;
                sv_n      = 1'b1;
                left_ok_n = 1'b0;
              end
            end
          end
        end
        default: state_n = SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_adc_deserializer.sv
// Directed bench for i2s_adc_deserializer: drives I2S slots, captures every
// strobe and compares against hand-computed frames.
module tb_i2s_adc_deserializer;
  localparam int DATA_W      = 16;
  localparam int SYNC_STAGES = 2;

  logic                     clk     = 1'b0;
  logic                     reset_n = 1'b1;
  logic                     bclk    = 1'b0;
  logic                     lrck    = 1'b0;
  logic                     data    = 1'b0;
  logic signed [DATA_W-1:0] adc_left, adc_right;
  logic                     sample_valid, frame_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int half = 8;
  int last_rise_cyc = 0;

  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int          sv_cyc_q[$];
  int          fe_count = 0;
  int          exp_fe = 0;
  int          b2b_count = 0;
  logic        sv_prev = 1'b0;
  logic        fe_prev = 1'b0;
  logic [15:0] last_l, last_r;

  i2s_adc_deserializer #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bclk         (bclk),
    .lrck         (lrck),
    .data         (data),
    .adc_left     (adc_left),
    .adc_right    (adc_right),
    .sample_valid (sample_valid),
    .frame_err    (frame_err)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture strobes on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (sample_valid) begin
      got_q.push_back({adc_left, adc_right});
      sv_cyc_q.push_back(cyc);
    end
    if (frame_err) fe_count++;
    if ((sample_valid && sv_prev) || (frame_err && fe_prev)) b2b_count++;
    sv_prev = sample_valid;
    fe_prev = frame_err;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One BCLK period: data and lrck change with the falling edge
  task automatic bit_clock(input logic lr, input logic d, input bit mark);
    bclk = 1'b0;
    lrck = lr;
    data = d;
    repeat (half) @(posedge clk);
    #1;
    bclk = 1'b1;
    if (mark) last_rise_cyc = cyc;
    repeat (half) @(posedge clk);
    #1;
  endtask

  // Slot bit 0 is the I2S delay slot; bits 1..nbits carry w MSB first
  task automatic send_slot(input logic lr, input logic [15:0] w, input int slot_len, input int nbits);
    for (int i = 0; i < slot_len; i++) begin
      logic d;
      d = (i >= 1 && i <= nbits) ? w[DATA_W - i] : 1'b0;
      bit_clock(lr, d, (i == nbits));
    end
  endtask

  task automatic apply_stimulus(input logic [15:0] l, input logic [15:0] r);
    send_slot(1'b0, l, 32, 16);
    send_slot(1'b1, r, 32, 16);
    exp_q.push_back({l, r});
  endtask

  task automatic check_output(input string tag);
    int n;
    repeat (8) @(posedge clk);
    #1;
    check_value({tag, " pulse count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check_value({tag, " frame"}, got_q[i], exp_q[i]);
    check_value({tag, " frame_err count"}, fe_count, exp_fe);
    got_q.delete();
    exp_q.delete();
    sv_cyc_q.delete();
    fe_count = 0;
    exp_fe   = 0;
  endtask

  initial begin
    int d, ok;
    logic [15:0] l, r;

    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_value("reset adc_left", $unsigned(adc_left), 0);
    check_value("reset adc_right", $unsigned(adc_right), 0);
    check_value("reset sample_valid", sample_valid, 0);
    check_value("reset frame_err", frame_err, 0);
    reset_n = 1'b1;

    // Stream enters mid right word: that word is discarded, then a full pair
    send_slot(1'b1, 16'h5A5A, 20, 16);
    apply_stimulus(16'h8001, 16'h7FFE);
    check_output("first frame");
    check_value("hold adc_left", $unsigned(adc_left), 32'h8001);
    check_value("hold adc_right", $unsigned(adc_right), 32'h7FFE);

    // Three back-to-back frames: spacing and pin-to-strobe latency
    apply_stimulus(16'h0001, 16'hFFFF);
    apply_stimulus(16'h1234, 16'hEDCB);
    apply_stimulus(16'h8000, 16'h7FFF);
    repeat (8) @(posedge clk);
    #1;
    check_value("b2b pulse count", sv_cyc_q.size(), 3);
    if (sv_cyc_q.size() == 3) begin
      for (int i = 1; i < 3; i++) begin
        d  = sv_cyc_q[i] - sv_cyc_q[i-1];
        ok = (d >= 1023 && d <= 1025) ? 1 : 0;
        check_value("frame spacing", ok, 1);
      end
      // The clk cycle in which the bclk pin rises counts as cycle 1
      check_value("latency", sv_cyc_q[2] - last_rise_cyc + 1, SYNC_STAGES + 2);
    end
    check_output("three frames");

    // Left word cut after 10 bits, its right word must not strobe
    send_slot(1'b0, 16'hFFFF, 11, 10);
    send_slot(1'b1, 16'hABCD, 32, 16);
    exp_fe = 1;
    apply_stimulus(16'h00FF, 16'hFF00);
    check_output("truncation");

    // Minimum BCLK ratio with random words
    half = 2;
    last_l = '0;
    last_r = '0;
    for (int i = 0; i < 100; i++) begin
      l = 16'($urandom);
      r = 16'($urandom);
      apply_stimulus(l, r);
      last_l = l;
      last_r = r;
    end
    check_output("clk/4 random");
    check_value("pre-reset adc_left", $unsigned(adc_left), {16'h0, last_l});
    check_value("pre-reset adc_right", $unsigned(adc_right), {16'h0, last_r});

    // Reset in the middle of a left word
    half = 8;
    send_slot(1'b0, 16'h1357, 9, 8);
    reset_n = 1'b0;
    #1;
    check_value("async reset adc_left", $unsigned(adc_left), 0);
    check_value("async reset adc_right", $unsigned(adc_right), 0);
    repeat (3) @(posedge clk);
    #1;
    check_value("in reset sample_valid", sample_valid, 0);
    reset_n = 1'b1;
    send_slot(1'b1, 16'h2468, 32, 16);
    apply_stimulus(16'h0F0F, 16'hF0F0);
    check_output("reset recovery");

    check_value("back-to-back strobes", b2b_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
